// File: rtl/xgmii_decoder.sv
// 64b/66b receive decoder: rebuilds each 66-bit block from two 32-bit halves and
// emits two XGMII words per block, substituting /E/ blocks for illegal input.
module xgmii_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_encoded_data,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  input  logic                  i_hdr_valid,
  input  logic                  i_encoded_data_valid,
  output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
  output logic                  o_xgmii_valid,
  output logic                  o_decoding_err
);

  localparam int LANES = 2 * CTRL_WIDTH;
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{8'h07}};
  localparam logic [DATA_WIDTH-1:0] ERR_WORD  = {CTRL_WIDTH{8'hFE}};

  typedef enum logic {EXP_FIRST, EXP_SECOND} in_state_t;
  typedef enum logic {OUT_PKT, IN_PKT} frame_t;

  in_state_t state_reg, state_next;
  frame_t    frame_reg, frame_next;

  logic [DATA_WIDTH-1:0] held_data_reg;
  logic [HDR_WIDTH-1:0]  held_hdr_reg;
  logic [DATA_WIDTH-1:0] pend_rxd_reg;
  logic [CTRL_WIDTH-1:0] pend_rxc_reg;
  logic                  pend_valid_reg;
  logic [DATA_WIDTH-1:0] rxd_reg;
  logic [CTRL_WIDTH-1:0] rxc_reg;
  logic                  valid_reg;
  logic                  err_reg;

  logic capture, decode, seq_err;

  logic [2*DATA_WIDTH-1:0] blk;
  logic [2*DATA_WIDTH-1:0] blk_hi;
  logic [7:0]              ctl_char [LANES];
  logic [LANES-1:0]        ctl_ok;

  assign blk    = {i_encoded_data, held_data_reg};
  assign blk_hi = {8'h00, blk[2*DATA_WIDTH-1:8]};

  // 7-bit control code of lane gi, at its fixed position after the type byte
  for (genvar gi = 0; gi < LANES; gi++) begin : g_ctl
    logic [6:0] code;
    assign code         = blk[7*gi+8 +: 7];
    assign ctl_ok[gi]   = (code == 7'h00) || (code == 7'h1E);
    assign ctl_char[gi] = (code == 7'h1E) ? 8'hFE : 8'h07;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    decode     = 1'b0;
    seq_err    = 1'b0;
    if (i_encoded_data_valid) begin
      case (state_reg)
        EXP_FIRST: begin
          if (i_hdr_valid) begin
            capture    = 1'b1;
            state_next = EXP_SECOND;
          end else begin
            seq_err = 1'b1;
          end
        end
        default: begin
          if (!i_hdr_valid) begin
            decode     = 1'b1;
            state_next = EXP_FIRST;
          end else begin
            seq_err = 1'b1;
            capture = 1'b1;
          end
        end
      endcase
    end
  end

  logic [2*DATA_WIDTH-1:0] dec_rxd, out_rxd;
  logic [LANES-1:0]        dec_rxc, out_rxc;
  logic dec_bad, blk_err, is_data, is_start, is_term, is_ctrl, t_type;
  int   tpos;

  always_comb begin
    dec_rxd  = '0;
    dec_rxc  = '0;
    dec_bad  = 1'b0;
    is_data  = 1'b0;
    is_start = 1'b0;
    is_term  = 1'b0;
    is_ctrl  = 1'b0;
    t_type   = 1'b1;
    case (blk[7:0])
      8'h87:   tpos = 0;
      8'h99:   tpos = 1;
      8'hAA:   tpos = 2;
      8'hB4:   tpos = 3;
      8'hCC:   tpos = 4;
      8'hD2:   tpos = 5;
      8'hE1:   tpos = 6;
      8'hFF:   tpos = 7;
      default: begin
        tpos   = 0;
        t_type = 1'b0;
      end
    endcase

    if (held_hdr_reg == 2'b01) begin
      dec_rxd = blk;
      is_data = 1'b1;
    end else if (held_hdr_reg == 2'b10) begin
      is_ctrl = 1'b1;
      if (blk[7:0] == 8'h1E) begin
        for (int j = 0; j < LANES; j++) begin
          dec_rxd[8*j +: 8] = ctl_char[j];
          dec_bad           = dec_bad | ~ctl_ok[j];
        end
        dec_rxc = '1;
      end else if (blk[7:0] == 8'h78) begin
        dec_rxd  = {blk[2*DATA_WIDTH-1:8], 8'hFB};
        dec_rxc  = 8'h01;
        is_start = 1'b1;
      end else if (blk[7:0] == 8'h33) begin
        for (int j = 0; j < 4; j++) begin
          dec_rxd[8*j +: 8] = ctl_char[j];
          dec_bad           = dec_bad | ~ctl_ok[j];
        end
        dec_rxd[2*DATA_WIDTH-1:32] = {blk[2*DATA_WIDTH-1:40], 8'hFB};
        dec_rxc  = 8'h1F;
        is_start = 1'b1;
      end else if (t_type) begin
        is_term = 1'b1;
        // data lanes sit in bytes 1..tpos, control codes fill the tail
        for (int j = 0; j < LANES; j++) begin
          if (j < tpos) begin
            dec_rxd[8*j +: 8] = blk_hi[8*j +: 8];
          end else if (j == tpos) begin
            dec_rxd[8*j +: 8] = 8'hFD;
            dec_rxc[j]        = 1'b1;
          end else begin
            dec_rxd[8*j +: 8] = ctl_char[j];
            dec_rxc[j]        = 1'b1;
            dec_bad           = dec_bad | ~ctl_ok[j];
          end
        end
      end else begin
        dec_bad = 1'b1;
      end
    end else begin
      dec_bad = 1'b1;
    end

    blk_err = dec_bad
            | ((frame_reg == OUT_PKT) & (is_data | is_term))
            | ((frame_reg == IN_PKT) & is_ctrl & ~is_term);

    if (blk_err)       frame_next = OUT_PKT;
    else if (is_start) frame_next = IN_PKT;
    else if (is_term)  frame_next = OUT_PKT;
    else               frame_next = frame_reg;

    out_rxd = blk_err ? {2{ERR_WORD}} : dec_rxd;
    out_rxc = blk_err ? '1 : dec_rxc;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= EXP_FIRST;
      frame_reg      <= OUT_PKT;
      held_data_reg  <= '0;
      held_hdr_reg   <= '0;
      pend_rxd_reg   <= '0;
      pend_rxc_reg   <= '0;
      pend_valid_reg <= 1'b0;
      rxd_reg        <= IDLE_WORD;
      rxc_reg        <= '1;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= seq_err | (decode & blk_err);
      if (capture) begin
        held_data_reg <= i_encoded_data;
        held_hdr_reg  <= i_sync_hdr;
      end
      if (decode) begin
        frame_reg      <= frame_next;
        rxd_reg        <= out_rxd[DATA_WIDTH-1:0];
        rxc_reg        <= out_rxc[CTRL_WIDTH-1:0];
        valid_reg      <= 1'b1;
        pend_rxd_reg   <= out_rxd[2*DATA_WIDTH-1:DATA_WIDTH];
        pend_rxc_reg   <= out_rxc[LANES-1:CTRL_WIDTH];
        pend_valid_reg <= 1'b1;
      end else if (pend_valid_reg) begin
        rxd_reg        <= pend_rxd_reg;
        rxc_reg        <= pend_rxc_reg;
        valid_reg      <= 1'b1;
        pend_valid_reg <= 1'b0;
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_xgmii_rxd    = rxd_reg;
  assign o_xgmii_rxc    = rxc_reg;
  assign o_xgmii_valid  = valid_reg;
  assign o_decoding_err = err_reg;

endmodule

// File: tb/tb_xgmii_decoder.sv
// Bench for xgmii_decoder: directed blocks plus random legal frames built from XGMII
// lane contents, encoded here and compared word-by-word (with timing) on the output.
module tb_xgmii_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] enc_data = '0;
  logic [1:0]  sync_hdr = '0;
  logic        hdr_valid = 1'b0;
  logic        enc_valid = 1'b0;
  logic [31:0] rxd;
  logic [3:0]  rxc;
  logic        xvalid, derr;

  int unsigned cyc = 0;
  int n_tests = 0, n_fail = 0;
  int seq_err_seen = 0, seq_err_exp = 0;

  typedef struct packed {
    int unsigned cyc;
    logic        err;
    logic [3:0]  rxc;
    logic [31:0] rxd;
  } word_t;

  word_t obs_q[$], exp_q[$];
  word_t mon_w;
  logic [7:0] ttype [8];

  xgmii_decoder dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_encoded_data       (enc_data),
    .i_sync_hdr           (sync_hdr),
    .i_hdr_valid          (hdr_valid),
    .i_encoded_data_valid (enc_valid),
    .o_xgmii_rxd          (rxd),
    .o_xgmii_rxc          (rxc),
    .o_xgmii_valid        (xvalid),
    .o_decoding_err       (derr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (xvalid) begin
      mon_w.cyc = cyc;
      mon_w.err = derr;
      mon_w.rxc = rxc;
      mon_w.rxd = rxd;
      obs_q.push_back(mon_w);
    end else if (derr) begin
      seq_err_seen++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic hv, input logic [1:0] h,
                           output int unsigned k);
    @(negedge clk);
    enc_data  = d;
    hdr_valid = hv;
    sync_hdr  = h;
    enc_valid = 1'b1;
    k = cyc + 1;
    @(posedge clk);
    #1 enc_valid = 1'b0;
    hdr_valid = 1'b0;
  endtask

  task automatic push_exp(input int unsigned k, input logic e, input logic [3:0] c,
                          input logic [31:0] r);
    word_t w;
    w.cyc = k;
    w.err = e;
    w.rxc = c;
    w.rxd = r;
    exp_q.push_back(w);
  endtask

  task automatic send_block(input logic [1:0] h, input logic [63:0] blk,
                            input logic [31:0] r0, input logic [3:0] c0,
                            input logic [31:0] r1, input logic [3:0] c1,
                            input logic e, input int gap);
    int unsigned k;
    send_word(blk[31:0], 1'b1, h, k);
    repeat (gap) @(posedge clk);
    send_word(blk[63:32], 1'b0, 2'($urandom), k);
    push_exp(k, e, c0, r0);
    push_exp(k + 1, 1'b0, c1, r1);
  endtask

  task automatic send_idle();
    send_block(2'b10, 64'h1E, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0, 0);
  endtask

  task automatic send_bad(input logic [1:0] h, input logic [63:0] blk);
    send_block(h, blk, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1, 0);
  endtask

  task automatic drain(input string tag);
    word_t o, e;
    repeat (4) @(negedge clk);
    check({tag, "/count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "/word"}, {27'b0, o.err, o.rxc, o.rxd}, {27'b0, e.err, e.rxc, e.rxd});
      check({tag, "/cycle"}, 64'(o.cyc), 64'(e.cyc));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "/seq_err"}, 64'(seq_err_seen), 64'(seq_err_exp));
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  // Random legal block: lanes/ctl are the XGMII characters the encoder started from
  task automatic rand_block(input logic [1:0] h, input logic [63:0] blk,
                            input logic [63:0] lanes, input logic [7:0] ctl);
    repeat (rgap()) @(posedge clk);
    send_block(h, blk, lanes[31:0], ctl[3:0], lanes[63:32], ctl[7:4], 1'b0, rgap());
  endtask

  task automatic gen_frame();
    logic [63:0] ln, blk;
    logic [7:0]  ct;
    int n;
    repeat ($urandom_range(0, 2)) rand_block(2'b10, 64'h1E, {2{32'h07070707}}, 8'hFF);
    ln = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) begin
      ln[7:0] = 8'hFB;
      ct  = 8'h01;
      blk = {ln[63:8], 8'h78};
    end else begin
      ln[39:0] = {8'hFB, 32'h07070707};
      ct  = 8'h1F;
      blk = {ln[63:40], 32'h0, 8'h33};
    end
    rand_block(2'b10, blk, ln, ct);
    repeat ($urandom_range(0, 3)) begin
      ln = {$urandom, $urandom};
      rand_block(2'b01, ln, ln, 8'h00);
    end
    n   = $urandom_range(0, 7);
    ln  = {$urandom, $urandom};
    blk = 64'(ttype[n]);
    ct  = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (j < n) begin
        blk = blk | (64'(ln[8*j +: 8]) << (8*j + 8));
      end else begin
        ln[8*j +: 8] = (j == n) ? 8'hFD : 8'h07;
        ct[j] = 1'b1;
      end
    end
    rand_block(2'b10, blk, ln, ct);
  endtask

  initial begin
    int unsigned k;
    ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst/rxd", 64'(rxd), 64'h07070707);
    check("rst/rxc", 64'(rxc), 64'hF);
    check("rst/valid", 64'(xvalid), 64'h0);
    check("rst/err", 64'(derr), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Idle, then the reference packet: start / data / T0
    send_idle();
    send_block(2'b10, 64'h77665544_33221178, 32'h332211FB, 4'h1, 32'h77665544, 4'h0, 1'b0, 0);
    send_block(2'b01, 64'h44332211_DDCCBBAA, 32'hDDCCBBAA, 4'h0, 32'h44332211, 4'h0, 1'b0, 1);
    send_block(2'b10, 64'h87, 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 1'b0, 0);
    drain("packet");

    // Illegal blocks while out of packet
    send_bad(2'b00, 64'h1E);
    send_bad(2'b01, 64'h0123456789ABCDEF);
    send_bad(2'b10, 64'h55);
    send_bad(2'b10, 64'h1E | (64'h2A << 29));
    send_bad(2'b10, 64'hAA);
    send_block(2'b10, 64'h1E1E, 32'h070707FE, 4'hF, 32'h07070707, 4'hF, 1'b0, 0);
    drain("out_pkt_err");

    // Frame violations inside a packet; each error forces OUT_PKT
    send_block(2'b10, 64'h78, 32'h000000FB, 4'h1, 32'h0, 4'h0, 1'b0, 0);
    send_bad(2'b10, 64'h78);
    send_bad(2'b01, 64'h1111111122222222);
    send_block(2'b10, 64'h78, 32'h000000FB, 4'h1, 32'h0, 4'h0, 1'b0, 0);
    send_bad(2'b10, 64'h1E);
    send_block(2'b10, 64'h78, 32'h000000FB, 4'h1, 32'h0, 4'h0, 1'b0, 0);
    send_bad(2'b11, 64'h1E);
    send_bad(2'b10, 64'hFF);
    drain("in_pkt_err");

    // Header sequencing faults
    repeat (3) @(posedge clk);
    send_word(32'hAABBCCDD, 1'b1, 2'b01, k);
    seq_err_exp++;
    send_idle();
    repeat (3) @(posedge clk);
    send_word(32'h12345678, 1'b0, 2'b10, k);
    seq_err_exp++;
    send_idle();
    drain("seq");

    // Reset between halves: held half discarded, frame state back to OUT_PKT
    send_block(2'b10, 64'h77665544_33221178, 32'h332211FB, 4'h1, 32'h77665544, 4'h0, 1'b0, 0);
    repeat (3) @(posedge clk);
    send_word(32'hDDCCBBAA, 1'b1, 2'b01, k);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid/rxd", 64'(rxd), 64'h07070707);
    check("rst_mid/rxc", 64'(rxc), 64'hF);
    check("rst_mid/valid", 64'(xvalid), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_word(32'h44332211, 1'b0, 2'b01, k);
    seq_err_exp++;
    repeat (2) @(posedge clk);
    send_bad(2'b01, 64'h44332211_DDCCBBAA);
    drain("rst_mid_block");

    // Reset while word1 is pending: it must never appear
    send_word(32'h332211_78, 1'b1, 2'b10, k);
    send_word(32'h77665544, 1'b0, 2'b10, k);
    push_exp(k, 1'b0, 4'h1, 32'h332211FB);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out/valid", 64'(xvalid), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_idle();
    drain("rst_mid_out");

    for (int f = 0; f < 100; f++) gen_frame();
    send_idle();
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
